// File: rtl/inst_fetch_unit_if.sv
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Fetch-stage bus bundle: imem request/response, redirect, decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     fetch_count;

    // master = fetch unit, slave = memory/decode/branch environment
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, fetch_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
               redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, fetch_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
               redirect_pc, if_ready
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Sequential-PC instruction fetch with a reservation queue and
//            redirect flush. Optional macro IFU_FETCH_COUNT_EN enables the
//            delivered-instruction counter on fetch_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    inst_fetch_unit_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          PW      = AW + 1;
    localparam logic [PW:0] c_DEPTH = (PW+1)'(DEPTH);

    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [XLEN-1:0]  r_inst [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_fill;
    logic [PW-1:0]    r_drop;
    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_started;

    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_tail_idx;
    logic [AW-1:0]    w_fill_idx;
    logic [PW-1:0]    w_count;
    logic [PW-1:0]    w_pend;
    logic [PW:0]      w_credit_used;
    logic [PW:0]      w_redirect_drop;
    logic             w_if_valid;
    logic             w_deq;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_resp_drop;
    logic             w_resp_fill;
    logic             w_resp_live;

    assign w_head_idx = r_head[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];
    assign w_fill_idx = r_fill[AW-1:0];
    assign w_count    = r_tail - r_head;
    assign w_pend     = r_tail - r_fill;
    assign w_if_valid = r_filled[w_head_idx];
    assign w_deq      = w_if_valid & bus.if_ready;

    // A slot being dequeued this cycle is reusable now, so a full queue that
    // drains every cycle still issues every cycle.
    assign w_credit_used = {1'b0, w_count} - {{PW{1'b0}}, w_deq} + {1'b0, r_drop};
    assign w_req_valid   = r_started & (w_credit_used < c_DEPTH);
    assign w_req_fire    = w_req_valid & bus.imem_req_ready;

    assign w_resp_drop = bus.imem_resp_valid & (r_drop != '0);
    assign w_resp_fill = bus.imem_resp_valid & (r_drop == '0) & (w_pend != '0);
    assign w_resp_live = w_resp_drop | w_resp_fill;

    // Everything still owed by memory after this edge, all of it stale.
    assign w_redirect_drop = {1'b0, r_drop} + {1'b0, w_pend}
                           + {{PW{1'b0}}, w_req_fire} - {{PW{1'b0}}, w_resp_live};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_inst        = r_inst[w_head_idx];
    assign bus.if_pc          = r_pc[w_head_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_drop     <= '0;
            r_filled   <= '0;
            r_started  <= 1'b0;
            r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else begin
            r_started <= 1'b1;
            if (bus.redirect_valid) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_fill     <= '0;
                r_filled   <= '0;
                r_drop     <= w_redirect_drop[PW-1:0];
                r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else begin
                if (w_req_fire) begin
                    r_pc[w_tail_idx] <= r_fetch_pc;
                    r_tail           <= r_tail + PW'(1);
                    r_fetch_pc       <= r_fetch_pc + XLEN'(4);
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - PW'(1);
                end
                // Fill slot is never the dequeued head: the head is filled, the fill slot is not.
                if (w_resp_fill) begin
                    r_inst[w_fill_idx]   <= bus.imem_resp_data;
                    r_filled[w_fill_idx] <= 1'b1;
                    r_fill               <= r_fill + PW'(1);
                end
                if (w_deq) begin
                    r_filled[w_head_idx] <= 1'b0;
                    r_head               <= r_head + PW'(1);
                end
            end
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_deq) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`else
    assign bus.fetch_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Directed self-checking bench for inst_fetch_unit (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;
`ifdef IFU_FETCH_COUNT_EN
    localparam logic [31:0] c_EXP_COUNT = 32'd5;
`else
    localparam logic [31:0] c_EXP_COUNT = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_en;
    int          fire_cnt;
    int          n_checks;
    int          n_errors;
    logic [31:0] mem_q[$];

    inst_fetch_unit_if #(.XLEN(32)) bus ();

    inst_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory: answers in the cycle after acceptance when enabled,
    // otherwise holds accepted addresses until re-enabled. Data = address.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= '0;
            fire_cnt            <= 0;
        end else begin
            bus.imem_resp_valid <= 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_q.push_back(bus.imem_req_addr);
                fire_cnt <= fire_cnt + 1;
            end
            if (mem_en && mem_q.size() != 0) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= mem_q.pop_front();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks               = 0;
        n_errors               = 0;
        rst_n                  = 1'b0;
        mem_en                 = 1'b1;
        bus.imem_req_ready     = 1'b1;
        bus.redirect_valid     = 1'b0;
        bus.redirect_pc        = '0;
        bus.if_ready           = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid",  32'(bus.if_valid),       32'd0);
        chk("rst_if_inst",   bus.if_inst,             32'h0);
        chk("rst_if_pc",     bus.if_pc,               32'h0);
        chk("rst_fcount",    bus.fetch_count,         32'h0);

        // Streaming with zero-wait memory and decode always ready
        rst_n = 1'b1;
        step();
        chk("s_req_valid0", 32'(bus.imem_req_valid), 32'd1);
        chk("s_addr0",      bus.imem_req_addr,        32'h0);
        step();
        chk("s_addr1",      bus.imem_req_addr,        32'h4);
        step();
        chk("s_if_valid0",  32'(bus.if_valid),        32'd1);
        chk("s_if_pc0",     bus.if_pc,                32'h0);
        chk("s_if_inst0",   bus.if_inst,              32'h0);
        step();
        chk("s_if_pc1",     bus.if_pc,                32'h4);
        chk("s_if_inst1",   bus.if_inst,              32'h4);
        step();
        chk("s_if_valid2",  32'(bus.if_valid),        32'd1);
        chk("s_if_pc2",     bus.if_pc,                32'h8);

        // Decode stalled: only DEPTH requests go out
        bus.if_ready = 1'b0;
        do_reset();
        repeat (12) step();
        chk("bp_fires",     32'(fire_cnt),            32'd2);
        chk("bp_req_valid", 32'(bus.imem_req_valid),  32'd0);
        chk("bp_if_pc0",    bus.if_pc,                32'h0);
        bus.if_ready = 1'b1;
        #1;
        chk("bp_resume_v",  32'(bus.imem_req_valid),  32'd1);
        chk("bp_resume_a",  bus.imem_req_addr,        32'h8);
        step();
        chk("bp_if_pc1",    bus.if_pc,                32'h4);
        step();
        chk("bp_if_pc2",    bus.if_pc,                32'h8);

        // Memory not ready: address held
        bus.imem_req_ready = 1'b0;
        do_reset();
        step();
        chk("nr_valid",     32'(bus.imem_req_valid),  32'd1);
        chk("nr_addr_c1",   bus.imem_req_addr,        32'h0);
        step();
        chk("nr_addr_c2",   bus.imem_req_addr,        32'h0);
        step();
        chk("nr_addr_c3",   bus.imem_req_addr,        32'h0);
        bus.imem_req_ready = 1'b1;
        step();
        chk("nr_addr_go",   bus.imem_req_addr,        32'h4);
        chk("nr_fires",     32'(fire_cnt),            32'd1);

        // Redirect with two requests outstanding
        mem_en = 1'b0;
        do_reset();
        repeat (3) step();
        chk("rd_full_v",    32'(bus.imem_req_valid),  32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_if_valid",  32'(bus.if_valid),        32'd0);
        chk("rd_credit0",   32'(bus.imem_req_valid),  32'd0);
        mem_en = 1'b1;
        step();
        chk("rd_credit1",   32'(bus.imem_req_valid),  32'd0);
        step();
        chk("rd_addr",      bus.imem_req_addr,        32'h100);
        repeat (2) step();
        chk("rd_if_pc0",    bus.if_pc,                32'h100);
        chk("rd_if_inst0",  bus.if_inst,              32'h100);
        step();
        chk("rd_if_pc1",    bus.if_pc,                32'h104);

        // Unaligned redirect coinciding with a response
        bus.if_ready = 1'b0;
        do_reset();
        repeat (2) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        step();
        bus.redirect_valid = 1'b0;
        chk("ra_if_valid",  32'(bus.if_valid),        32'd0);
        chk("ra_req_valid", 32'(bus.imem_req_valid),  32'd1);
        chk("ra_addr",      bus.imem_req_addr,        32'h200);
        repeat (2) step();
        chk("ra_if_valid2", 32'(bus.if_valid),        32'd1);
        chk("ra_if_pc",     bus.if_pc,                32'h200);
        chk("ra_if_inst",   bus.if_inst,              32'h200);

        // Five handshakes then a redirect; counter survives redirect
        do_reset();
        repeat (4) step();
        bus.if_ready = 1'b1;
        repeat (5) step();
        bus.if_ready = 1'b0;
        chk("fc_if_valid",  32'(bus.if_valid),        32'd1);
        chk("fc_if_pc",     bus.if_pc,                32'h14);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        chk("fc_count",     bus.fetch_count,          c_EXP_COUNT);
        chk("fc_if_valid2", 32'(bus.if_valid),        32'd0);

        // Reset in mid-operation
        rst_n = 1'b0;
        step();
        chk("mr_req_valid", 32'(bus.imem_req_valid),  32'd0);
        chk("mr_if_valid",  32'(bus.if_valid),        32'd0);
        chk("mr_count",     bus.fetch_count,          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage; the producer end of the instruction stream that the opcode decoder/main controller consumes.
- Generates sequential PCs and issues in-order requests to instruction memory.
- Buffers returned instructions with their PCs in a small reservation queue.
- Presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight fetches.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, queue entries = max outstanding+buffered fetches; power of 2, ≥2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, bits[1:0] always 0
imem_resp_valid  in  1  response valid, in request order, max one per cycle
imem_resp_data  in  XLEN  instruction word
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  restart address
if_valid  out  1  instruction available to decode
if_ready  in  1  decode consumes instruction
if_inst  out  XLEN  instruction word (opcode = bits[6:0])
if_pc  out  XLEN  PC of if_inst
fetch_count  out  32  retired-to-decode counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC; queue empty; drop_cnt=0.
  - imem_req_valid=0, if_valid=0, if_inst=0, if_pc=0, fetch_count=0.
  - Reset mid-operation discards all state; any later responses for pre-reset requests are the memory's responsibility (memory is reset by the same rst_n).
- Issue:
  - imem_req_valid=1 when reserved entries + drop_cnt < DEPTH.
  - imem_req_addr=fetch_pc.
  - On valid&ready: reserve tail entry {pc=fetch_pc, filled=0}; fetch_pc+=4 (wraps modulo 2^XLEN).
  - While valid&!ready, addr stays stable unless a redirect occurs.
- Response:
  - If drop_cnt>0: discard data, drop_cnt--.
  - Otherwise write data to the oldest unfilled entry and set filled=1.
  - A response with no outstanding request is ignored.
- Output:
  - if_valid = head entry filled; if_inst/if_pc driven from head (combinational from queue registers).
  - if_valid&if_ready frees head; head advances.
  - Enqueue-reserve, fill and dequeue may all occur in the same cycle.
  - Full queue: no issue. Empty queue: if_valid=0.
- Redirect (highest priority):
  - On redirect_valid at posedge:
    - Queue cleared.
    - drop_cnt = count of issued-but-unanswered requests, excluding a response arriving this same cycle, which is itself dropped.
    - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - A request accepted in the same cycle as redirect also counts toward drop_cnt.
  - if_valid=0 the cycle after redirect; a dequeue handshake in the redirect cycle still completes.
  - First post-redirect request is issued the next cycle if credit allows.
- Latency:
  - Request issued the cycle after reset release.
  - Instruction visible on if_* the cycle after its response.
  - Zero-wait memory plus if_ready=1 sustains 1 instr/cycle with DEPTH≥2.

Optional Feature:
Macro IFU_FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on each if_valid&if_ready; wraps at 2^32; cleared by reset, not by redirect.
- Undefined: fetch_count tied to 0; no counter logic.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory echoing addr as data, if_ready=1 -> requests 0x0,0x4,0x8…; if_pc/if_inst pairs 0x0/0x0, 0x4/0x4 on consecutive cycles.
- if_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, imem_req_valid=0 thereafter; on release, PCs 0x0,0x4 delivered in order and fetch resumes at 0x8.
- imem_req_ready=0 for 3 cycles with valid=1 -> imem_req_addr held at 0x0, no PC advance.
- 2 requests outstanding, redirect_pc=0x100 -> next two responses discarded; first if_pc=0x100, next 0x104.
- redirect_pc=0x203 -> fetch starts at 0x200; redirect coinciding with a response -> that response dropped.
- IFU_FETCH_COUNT_EN defined, 5 handshakes plus 1 redirect -> fetch_count=5; undefined -> 0.
